// File: rtl/gumnut_data_mem_responder.sv
// gumnut_data_mem_responder
//
// Wishbone-classic responder for the Gumnut data bus. It owns the data RAM.
// It inserts WAIT_CYCLES wait states after a request, then terminates the
// transfer with a one-cycle ack. Read data comes from a register.
//
// Ports:
//   clk         - clock, all state changes on the rising edge
//   rst         - synchronous active-high reset
//   data_cyc_i  - bus cycle in progress
//   data_stb_i  - transfer strobe (request = cyc & stb)
//   data_we_i   - 1 = write, 0 = read, sampled with the request
//   data_adr_i  - word address, sampled with the request
//   data_dat_i  - write data, sampled with the request
//   data_dat_o  - registered read data, valid while data_ack_o = 1
//   data_ack_o  - transfer complete, one cycle wide
//   data_err_o  - error termination (only with DATA_MEM_ERR_EN)
//
// Optional feature macro: DATA_MEM_ERR_EN.
// When it is defined, an address >= DEPTH terminates with data_err_o
// instead of data_ack_o. No RAM write occurs and the read data is zero.
// When it is not defined, out-of-range addresses alias onto the RAM.

module gumnut_data_mem_responder #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_cyc_i,
  input  logic              data_stb_i,
  input  logic              data_we_i,
  input  logic [ADDR_W-1:0] data_adr_i,
  input  logic [DATA_W-1:0] data_dat_i,
  output logic [DATA_W-1:0] data_dat_o,
  output logic              data_ack_o
`ifdef DATA_MEM_ERR_EN
  ,
  output logic              data_err_o
`endif
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               we_q;
  logic [IDX_W-1:0]   idx_q;
  logic [DATA_W-1:0]  dat_q;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic               req;
  logic               in_idle;
  logic               enter_ack;
  logic               we_eff;
  logic [IDX_W-1:0]   idx_eff;
  logic [DATA_W-1:0]  dat_eff;
  logic               err_eff;

  assign req     = data_cyc_i & data_stb_i;
  assign in_idle = (state_q == S_IDLE);

  // With zero wait states, ACK is entered on the same edge that samples the
  // request. That edge must therefore use the live bus fields. From the
  // second cycle on, only the latched copies count.
  assign we_eff  = in_idle ? data_we_i : we_q;
  assign idx_eff = in_idle ? data_adr_i[IDX_W-1:0] : idx_q;
  assign dat_eff = in_idle ? data_dat_i : dat_q;

`ifdef DATA_MEM_ERR_EN
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  logic err_q;
  logic adr_oor;
  assign adr_oor = ({1'b0, data_adr_i} >= DEPTH_L);
  assign err_eff = in_idle ? adr_oor : err_q;
`else
  assign err_eff = 1'b0;
`endif

  // Next-state logic. ACK always falls back to IDLE. This guarantees an
  // idle cycle between transfers, so a strobe held high cannot double-ack.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            state_d = S_ACK;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign enter_ack = (state_d == S_ACK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request fields are captured only in IDLE. Changes the master makes
  // mid-transfer are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q  <= 1'b0;
      idx_q <= '0;
      dat_q <= '0;
    end else if (in_idle && req) begin
      we_q  <= data_we_i;
      idx_q <= data_adr_i[IDX_W-1:0];
      dat_q <= data_dat_i;
    end
  end

`ifdef DATA_MEM_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (in_idle && req) begin
      err_q <= adr_oor;
    end
  end

  assign data_ack_o = (state_q == S_ACK) && !err_q;
  assign data_err_o = (state_q == S_ACK) && err_q;
`else
  assign data_ack_o = (state_q == S_ACK);
`endif

  // Read data is loaded only on the edge that enters ACK. Otherwise it
  // holds its value, so writes leave it untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_dat_o <= '0;
    end else if (enter_ack) begin
      if (err_eff) begin
        data_dat_o <= '0;
      end else if (!we_eff) begin
        data_dat_o <= mem[idx_eff];
      end
    end
  end

  // The RAM has no reset. A write still in flight when reset hits is
  // dropped.
  always_ff @(posedge clk) begin
    if (!rst && enter_ack && we_eff && !err_eff) begin
      mem[idx_eff] <= dat_eff;
    end
  end

endmodule

// File: tb/tb_gumnut_data_mem_responder.sv
// tb_gumnut_data_mem_responder
//
// Drives two responder instances through directed transfers:
//   dut0: WAIT_CYCLES=0, DEPTH=256
//   dut1: WAIT_CYCLES=3, DEPTH=128
// A transaction-level model predicts ack/err/read data for every cycle.
// Literal expectations pin the key results.

module tb_gumnut_data_mem_responder;

`ifdef DATA_MEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk;
  logic       rstI [2];
  logic       cycI [2];
  logic       stbI [2];
  logic       weI  [2];
  logic [7:0] adrI [2];
  logic [7:0] datI [2];

  logic [7:0] datO0, datO1;
  logic       ackO0, ackO1, errO0, errO1;
  logic [7:0] datOut [2];
  logic       ackOut [2];
  logic       errOut [2];

  int checks   = 0;
  int failures = 0;
  bit started  = 0;

  gumnut_data_mem_responder #(
    .DATA_W(8), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(0)
  ) dut0 (
    .clk(clk), .rst(rstI[0]),
    .data_cyc_i(cycI[0]), .data_stb_i(stbI[0]), .data_we_i(weI[0]),
    .data_adr_i(adrI[0]), .data_dat_i(datI[0]),
    .data_dat_o(datO0), .data_ack_o(ackO0)
`ifdef DATA_MEM_ERR_EN
    , .data_err_o(errO0)
`endif
  );

  gumnut_data_mem_responder #(
    .DATA_W(8), .ADDR_W(8), .DEPTH(128), .WAIT_CYCLES(3)
  ) dut1 (
    .clk(clk), .rst(rstI[1]),
    .data_cyc_i(cycI[1]), .data_stb_i(stbI[1]), .data_we_i(weI[1]),
    .data_adr_i(adrI[1]), .data_dat_i(datI[1]),
    .data_dat_o(datO1), .data_ack_o(ackO1)
`ifdef DATA_MEM_ERR_EN
    , .data_err_o(errO1)
`endif
  );

`ifndef DATA_MEM_ERR_EN
  assign errO0 = 1'b0;
  assign errO1 = 1'b0;
`endif

  assign datOut[0] = datO0;
  assign datOut[1] = datO1;
  assign ackOut[0] = ackO0;
  assign ackOut[1] = ackO1;
  assign errOut[0] = errO0;
  assign errOut[1] = errO1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int waitOf(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic int depthOf(input int d);
    return (d == 0) ? 256 : 128;
  endfunction

  // The model is a transaction view. A request accepted while idle
  // completes WAIT_CYCLES edges later unless the strobe drops first.
  // A completion cycle cannot accept a new request.
  bit         expAck  [2];
  bit         expErr  [2];
  logic [7:0] expDat  [2];
  bit         mBusy   [2];
  int         mElapsed[2];
  bit         mWe     [2];
  logic [7:0] mAdr    [2];
  logic [7:0] mDat    [2];
  logic [7:0] mMem    [2][256];
  bit         mWasDone, mReq;
  int         mIdx;

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 256; a++) mMem[d][a] = 8'h00;
      mBusy[d] = 0;
      mElapsed[d] = 0;
      expAck[d] = 0;
      expErr[d] = 0;
      expDat[d] = 8'h00;
    end
  end

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rstI[d]) begin
        mBusy[d]  = 0;
        expAck[d] = 0;
        expErr[d] = 0;
        expDat[d] = 8'h00;
      end else begin
        mWasDone  = expAck[d] | expErr[d];
        expAck[d] = 0;
        expErr[d] = 0;
        mReq      = cycI[d] & stbI[d];
        if (mBusy[d] && !mReq) begin
          mBusy[d] = 0;
        end else if (mBusy[d]) begin
          mElapsed[d]++;
        end else if (!mWasDone && mReq) begin
          mBusy[d] = 1;
          mElapsed[d] = 0;
          mWe[d]  = weI[d];
          mAdr[d] = adrI[d];
          mDat[d] = datI[d];
        end
        if (mBusy[d] && mElapsed[d] == waitOf(d)) begin
          mBusy[d] = 0;
          if (ERR_EN && int'(mAdr[d]) >= depthOf(d)) begin
            expErr[d] = 1;
            expDat[d] = 8'h00;
          end else begin
            expAck[d] = 1;
            mIdx = int'(mAdr[d]) % depthOf(d);
            if (mWe[d]) mMem[d][mIdx] = mDat[d];
            else        expDat[d] = mMem[d][mIdx];
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int d,
                             input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s dut%0d: got 0x%0h expected 0x%0h", name, d, act, exp);
    end
  endtask

  // Every cycle after reset, the outputs must match the model.
  always @(negedge clk) begin
    if (started) begin
      for (int d = 0; d < 2; d++) begin
        checkOutput("cyc_ack", d, 32'(ackOut[d]), 32'(expAck[d]));
        checkOutput("cyc_err", d, 32'(errOut[d]), 32'(expErr[d]));
        checkOutput("cyc_dat", d, 32'(datOut[d]), 32'(expDat[d]));
      end
    end
  end

  // One transfer. dropAt > 0 drops the strobe in that cycle. mutate changes
  // the bus fields one cycle after the request was sampled. ackCycle is the
  // cycle number, counted from the sampling edge, in which ack or err was
  // seen.
  task automatic applyStimulus(input int d, input bit we, input logic [7:0] adr,
                               input logic [7:0] dat, input int dropAt, input bit mutate,
                               output logic [7:0] rdata, output int nAck,
                               output int nErr, output int ackCycle);
    nAck = 0; nErr = 0; rdata = 8'h00; ackCycle = -1;
    @(negedge clk);
    cycI[d] = 1'b1; stbI[d] = 1'b1; weI[d] = we; adrI[d] = adr; datI[d] = dat;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (mutate && k == 1) begin
        adrI[d] = adr ^ 8'h03; datI[d] = ~dat; weI[d] = ~we;
      end
      if (k == dropAt) stbI[d] = 1'b0;
      if (ackOut[d]) begin nAck++; rdata = datOut[d]; ackCycle = k; end
      if (errOut[d]) begin nErr++; ackCycle = k; end
      if (ackOut[d] || errOut[d]) break;
      if (dropAt > 0 && k > dropAt + 5) break;
    end
    cycI[d] = 1'b0; stbI[d] = 1'b0;
  endtask

  task automatic wr(input int d, input logic [7:0] adr, input logic [7:0] dat);
    logic [7:0] r; int na, ne, ac;
    applyStimulus(d, 1'b1, adr, dat, 0, 1'b0, r, na, ne, ac);
    checkOutput("wr_done", d, 32'(na + ne), 32'd1);
  endtask

  task automatic rdCheck(input int d, input string name, input logic [7:0] adr,
                         input logic [7:0] exp);
    logic [7:0] r; int na, ne, ac;
    applyStimulus(d, 1'b0, adr, 8'h00, 0, 1'b0, r, na, ne, ac);
    checkOutput({name, "_ack"}, d, 32'(na), 32'd1);
    checkOutput(name, d, 32'(r), 32'(exp));
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin : main
    logic [7:0] r;
    int na, ne, ac, total, staleAcks;

    for (int d = 0; d < 2; d++) begin
      rstI[d] = 1'b1; cycI[d] = 1'b0; stbI[d] = 1'b0;
      weI[d] = 1'b0; adrI[d] = 8'h00; datI[d] = 8'h00;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    started = 1;
    checkOutput("reset_ack", 0, 32'(ackOut[0]), 32'd0);
    checkOutput("reset_dat", 1, 32'(datOut[1]), 32'd0);
    rstI[0] = 1'b0; rstI[1] = 1'b0;

    // Zero wait states: write then read back.
    applyStimulus(0, 1'b1, 8'h10, 8'hA5, 0, 1'b0, r, na, ne, ac);
    checkOutput("w0_write_ack", 0, 32'(na), 32'd1);
    checkOutput("w0_write_latency", 0, 32'(ac), 32'd1);
    applyStimulus(0, 1'b0, 8'h10, 8'h00, 0, 1'b0, r, na, ne, ac);
    checkOutput("w0_read_latency", 0, 32'(ac), 32'd1);
    checkOutput("w0_read_data", 0, 32'(r), 32'hA5);
    checkOutput("model_pin_a5", 0, 32'(expDat[0]), 32'hA5);

    // Back-to-back write then read of the same word.
    total = 0;
    applyStimulus(0, 1'b1, 8'h05, 8'h11, 0, 1'b0, r, na, ne, ac);
    total += na;
    applyStimulus(0, 1'b0, 8'h05, 8'h00, 0, 1'b0, r, na, ne, ac);
    total += na;
    checkOutput("b2b_data", 0, 32'(r), 32'h11);
    checkOutput("b2b_ack_count", 0, 32'(total), 32'd2);

    // A strobe held high for four cycles gives two acks separated by idle.
    staleAcks = 0;
    @(negedge clk);
    cycI[0] = 1'b1; stbI[0] = 1'b1; weI[0] = 1'b0; adrI[0] = 8'h10;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (ackOut[0]) staleAcks++;
    end
    cycI[0] = 1'b0; stbI[0] = 1'b0;
    checkOutput("stale_stb_acks", 0, 32'(staleAcks), 32'd2);

    // Three wait states: preload, then latency and read data.
    wr(1, 8'h20, 8'h3C);
    wr(1, 8'h30, 8'h00);
    wr(1, 8'h40, 8'h44);
    wr(1, 8'h10, 8'h12);
    wr(1, 8'h22, 8'h5A);
    applyStimulus(1, 1'b0, 8'h20, 8'h00, 0, 1'b0, r, na, ne, ac);
    checkOutput("w3_read_latency", 1, 32'(ac), 32'd4);
    checkOutput("w3_read_data", 1, 32'(r), 32'h3C);

    // Aborted write leaves the old value.
    applyStimulus(1, 1'b1, 8'h30, 8'h55, 2, 1'b0, r, na, ne, ac);
    checkOutput("abort_no_ack", 1, 32'(na), 32'd0);
    rdCheck(1, "abort_old_value", 8'h30, 8'h00);

    // Reset during the wait of a write drops the write.
    rdCheck(1, "pre_reset_read", 8'h40, 8'h44);
    @(negedge clk);
    cycI[1] = 1'b1; stbI[1] = 1'b1; weI[1] = 1'b1; adrI[1] = 8'h40; datI[1] = 8'hBB;
    @(negedge clk);
    rstI[1] = 1'b1;
    @(negedge clk);
    checkOutput("rst_wait_ack", 1, 32'(ackOut[1]), 32'd0);
    checkOutput("rst_wait_dat", 1, 32'(datOut[1]), 32'd0);
    rstI[1] = 1'b0; cycI[1] = 1'b0; stbI[1] = 1'b0;
    rdCheck(1, "rst_write_dropped", 8'h40, 8'h44);

    // Bus fields that change mid-transfer are ignored.
    applyStimulus(1, 1'b1, 8'h21, 8'h77, 0, 1'b1, r, na, ne, ac);
    checkOutput("mutate_ack", 1, 32'(na), 32'd1);
    rdCheck(1, "mutate_latched", 8'h21, 8'h77);
    rdCheck(1, "mutate_untouched", 8'h22, 8'h5A);

    // Address 0x90 is beyond DEPTH=128.
    applyStimulus(1, 1'b1, 8'h90, 8'hEE, 0, 1'b0, r, na, ne, ac);
`ifdef DATA_MEM_ERR_EN
    checkOutput("oor_err", 1, 32'(ne), 32'd1);
    checkOutput("oor_no_ack", 1, 32'(na), 32'd0);
    rdCheck(1, "oor_no_write", 8'h10, 8'h12);
`else
    checkOutput("alias_ack", 1, 32'(na), 32'd1);
    checkOutput("alias_no_err", 1, 32'(ne), 32'd0);
    rdCheck(1, "alias_write", 8'h10, 8'hEE);
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
